// File: rtl/td4_prog_dumper.sv
// TD4 program-memory dumper: walks all 16 words and sends each as an 8N1 UART frame on tx.
// Optional macro TD4_DUMP_CHECKSUM_EN appends a 17th frame carrying the mod-256 sum of the bytes.
module td4_prog_dumper #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] mem_opcode,
  input  logic [3:0] mem_immediate,
  output logic [3:0] mem_addr,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    STOP,
    DONE
`ifdef TD4_DUMP_CHECKSUM_EN
    , CSUM_START
`endif
  } state_t;

  state_t            state;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic              baud_last;
  logic              fetch_last;
  logic              last_word;
  logic              csum_next;

`ifdef TD4_DUMP_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_sent;
`endif

  function automatic logic [7:0] add_mod256(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  always_comb begin
    baud_last  = (baud == BAUD_W'(CLKS_PER_BIT - 1));
    fetch_last = (baud != '0);
    last_word  = (mem_addr == 4'd15);
    csum_next  = 1'b0;
`ifdef TD4_DUMP_CHECKSUM_EN
    csum_next  = last_word && !csum_sent;
`endif
  end

  // Control FSM: all outputs registered, abort-on-reset from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_addr <= 4'd0;
      baud     <= '0;
      bit_cnt  <= 3'd0;
`ifdef TD4_DUMP_CHECKSUM_EN
      csum      <= 8'd0;
      csum_sent <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          done <= 1'b0;
          if (start) begin
            busy     <= 1'b1;
            mem_addr <= 4'd0;
            baud     <= '0;
            state    <= FETCH;
`ifdef TD4_DUMP_CHECKSUM_EN
            csum      <= 8'd0;
            csum_sent <= 1'b0;
`endif
          end
        end

        // Two cycles with a stable address cover both combinational and registered memories.
        FETCH: begin
          if (!fetch_last) begin
            baud <= baud + BAUD_W'(1);
          end else begin
            baud    <= '0;
            bit_cnt <= 3'd0;
            tx      <= 1'b0;
            state   <= START;
`ifdef TD4_DUMP_CHECKSUM_EN
            csum <= add_mod256(csum, {mem_opcode, mem_immediate});
`endif
          end
        end

        START
`ifdef TD4_DUMP_CHECKSUM_EN
        , CSUM_START
`endif
        : begin
          if (baud_last) begin
            baud  <= '0;
            tx    <= shift[0];
            state <= DATA;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end

        DATA: begin
          if (baud_last) begin
            baud <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end

        STOP: begin
          if (baud_last) begin
            baud    <= '0;
            bit_cnt <= 3'd0;
            if (csum_next) begin
              tx    <= 1'b0;
`ifdef TD4_DUMP_CHECKSUM_EN
              csum_sent <= 1'b1;
              state     <= CSUM_START;
`endif
            end else if (last_word) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              mem_addr <= mem_addr + 4'd1;
              state    <= FETCH;
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end

        DONE: begin
          done     <= 1'b0;
          busy     <= 1'b0;
          tx       <= 1'b1;
          mem_addr <= 4'd0;
          state    <= IDLE;
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Byte shifter: loaded on the fetch latch cycle (or with the sum), shifted at each data-bit end.
  always_ff @(posedge clk) begin
    if (state == FETCH && fetch_last) begin
      shift <= {mem_opcode, mem_immediate};
`ifdef TD4_DUMP_CHECKSUM_EN
    end else if (state == STOP && baud_last && csum_next) begin
      shift <= csum;
`endif
    end else if (state == DATA && baud_last) begin
      shift <= {1'b0, shift[7:1]};
    end
  end

endmodule

// File: tb/tb_td4_prog_dumper.sv
// Scoreboard bench for td4_prog_dumper: expected bytes are queued per dump, a UART monitor pops and compares.
module tb_td4_prog_dumper;

  localparam int CPB      = 4;
  localparam int WORD_CYC = 2 + 10 * CPB;
`ifdef TD4_DUMP_CHECKSUM_EN
  localparam int DUMP_CYC = 16 * WORD_CYC + 10 * CPB;
`else
  localparam int DUMP_CYC = 16 * WORD_CYC;
`endif
  localparam int FRAME_SAMPLES = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] mem_opcode;
  logic [3:0] mem_immediate;
  logic [3:0] mem_addr;
  logic       busy;
  logic       done;
  logic       tx;

  logic [7:0] mem [16];
  logic [7:0] exp_q [$];
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;

  logic       mon_active = 1'b0;
  int         mon_pos = 0;
  logic       samp [FRAME_SAMPLES];

  td4_prog_dumper #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mem_opcode   (mem_opcode),
    .mem_immediate(mem_immediate),
    .mem_addr     (mem_addr),
    .busy         (busy),
    .done         (done),
    .tx           (tx)
  );

  always #5 clk = ~clk;

  always_comb begin
    mem_opcode    = mem[mem_addr][7:4];
    mem_immediate = mem[mem_addr][3:0];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_frame();
    logic [9:0] fr;
    logic [7:0] got;
    logic [7:0] exp;
    int         bad;
    for (int b = 0; b < 8; b++) got[b] = samp[(b + 1) * CPB + CPB / 2];
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL frame: unexpected frame %02h, none expected", got);
    end else begin
      exp = exp_q.pop_front();
      fr  = {1'b1, exp, 1'b0};
      bad = 0;
      for (int i = 0; i < FRAME_SAMPLES; i++) if (samp[i] !== fr[i / CPB]) bad++;
      if (bad != 0) begin
        errors++;
        $display("FAIL frame: got %02h expected %02h (%0d samples off)", got, exp, bad);
      end
    end
  endtask

  // UART monitor: records each frame sample by sample; an abort (busy low mid-frame) drops it.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (mon_active && busy !== 1'b1) begin
      mon_active = 1'b0;
    end else if (mon_active) begin
      samp[mon_pos] = tx;
      mon_pos++;
      if (mon_pos == FRAME_SAMPLES) begin
        mon_active = 1'b0;
        check_frame();
      end
    end else if (tx === 1'b0 && busy === 1'b1) begin
      mon_active = 1'b1;
      samp[0]    = tx;
      mon_pos    = 1;
    end
  end

  task automatic run_dump(input int extra_at, input int rst_at);
    int   cyc;
    int   sum;
    logic prev_busy;
    bit   fin;
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(mem[i]);
      sum += mem[i];
    end
`ifdef TD4_DUMP_CHECKSUM_EN
    exp_q.push_back(8'(sum % 256));
`endif
    done_cnt = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("busy_after_accept", busy, 1);
    cyc = 0;
    prev_busy = busy;
    fin = 0;
    while (!fin) begin
      if (cyc == WORD_CYC - 1) chk("addr_word0", mem_addr, 0);
      if (cyc == WORD_CYC)     chk("addr_word1", mem_addr, 1);
      if (rst_at >= 0 && cyc == rst_at) begin
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        chk("abort_addr", mem_addr, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk("abort_stays_idle", {tx, busy}, 2'b10);
        return;
      end
      prev_busy = busy;
      @(negedge clk);
      cyc++;
      start = (cyc == extra_at);
      if (done === 1'b1) begin
        fin = 1;
      end else if (cyc > DUMP_CYC + 100) begin
        errors++;
        $display("FAIL done_timeout: no done after %0d cycles", cyc);
        fin = 1;
      end
    end
    start = 1'b0;
    chk("done_latency", cyc, DUMP_CYC);
    chk("busy_falls_with_done", {prev_busy, busy}, 2'b10);
    repeat (2) @(negedge clk);
    chk("done_pulses", done_cnt, 1);
    chk("frames_left", exp_q.size(), 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
  endtask

  initial begin
    bit tx_ok;
    rst   = 1'b1;
    start = 1'b0;
    fill_random();
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", mem_addr, 0);
    rst = 1'b0;
    tx_ok = 1;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) tx_ok = 0;
    end
    chk("idle_quiet", tx_ok, 1);

    fill_random();
    mem[0] = 8'h35;
    run_dump(-1, -1);

    for (int i = 0; i < 16; i++) mem[i] = {4'(i), ~4'(i)};
    run_dump(-1, -1);

    fill_random();
    run_dump(5 * WORD_CYC + 10, -1);

    fill_random();
    run_dump(-1, 7 * WORD_CYC + 2 + CPB + 3 * CPB + 1);
    fill_random();
    run_dump(-1, -1);

    for (int i = 0; i < 16; i++) mem[i] = 8'hFF;
    run_dump(-1, -1);

    repeat (2) begin
      fill_random();
      run_dump(-1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
